// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: single-port memory shared by fetch (IF) and load/store (DM), fixed-latency access, registered responses.
// Optional MEM_ARB_ALIGN_CHECK_EN adds if_err/dm_err and suppresses memory access for misaligned requests.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
`ifdef MEM_ARB_ALIGN_CHECK_EN
  output logic              if_err,
  output logic              dm_err,
`endif
  output logic              busy
);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve_cnt;
  logic win_dm, we_q, elig, gnt, mis, cap;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, dm_rdata_q;
  logic [31:0] if_rdata_q;
  // grants are gated by reset so nothing is granted while reset is asserted
  assign elig   = reset && state != WAIT;
  assign if_gnt = elig && if_req && (!dm_req || starve_cnt == SW'(STARVE_MAX));
  assign dm_gnt = elig && dm_req && !if_gnt;
  assign gnt    = if_gnt || dm_gnt;
`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic err_q;
  assign mis    = if_gnt ? |if_addr[1:0] : dm_gnt && |dm_addr[2:0];
  assign if_err = if_rvalid && err_q;
  assign dm_err = dm_rvalid && err_q;
`else
  assign mis    = 1'b0;
`endif
  assign mem_en    = gnt && !mis;
  assign mem_we    = dm_gnt && dm_we && !mis;
  assign mem_addr  = if_gnt ? if_addr : dm_gnt ? dm_addr : addr_q;
  assign mem_wdata = dm_gnt ? dm_wdata : wdata_q;
  assign cap       = state == WAIT && cnt == '0;
  assign stall_if  = if_req && !if_gnt;
  assign busy      = state != IDLE;
  assign if_rvalid = state == RESP && !win_dm;
  assign dm_rvalid = state == RESP && win_dm;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  always_comb begin
    state_nx = gnt ? (mis ? RESP : WAIT) : state == WAIT ? (cap ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      win_dm     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= gnt ? CW'(MEM_LAT - 1) : cnt - CW'(cnt != '0);
      if (gnt) begin
        win_dm  <= dm_gnt;
        we_q    <= dm_we;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
      if (dm_gnt && if_req) starve_cnt <= starve_cnt + SW'(starve_cnt != SW'(STARVE_MAX));
      else if (if_gnt || (elig && !if_req)) starve_cnt <= '0;
      if (cap && win_dm) dm_rdata_q <= we_q ? '0 : mem_rdata;
      if (cap && !win_dm) if_rdata_q <= mem_rdata[31:0];
`ifdef MEM_ARB_ALIGN_CHECK_EN
      if (gnt) err_q <= mis;
      if (if_gnt && mis) if_rdata_q <= '0;
      if (dm_gnt && mis) dm_rdata_q <= '0;
`endif
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: cycle-numbered reference model plus directed scenarios with literal expectations.
module tb_unified_mem_arbiter;
  localparam int LAT = 2, SMAX = 4;
  logic clk = 0, reset = 0;
  logic if_req = 0, dm_req = 0, dm_we = 0;
  logic [63:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, stall_if, busy;
  logic [31:0] if_rdata;
  logic [63:0] dm_rdata, mem_addr, mem_wdata;
`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic if_err, dm_err;
`endif
  unified_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if),
`ifdef MEM_ARB_ALIGN_CHECK_EN
    .if_err(if_err), .dm_err(dm_err),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, cyc = 0;
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask
  task automatic chk1(string name, logic got, logic exp);
    chk(name, {63'd0, got}, {63'd0, exp});
  endtask
  logic [63:0] mem [logic [63:0]];
  function automatic logic [63:0] rd(logic [63:0] a);
    return mem.exists(a) ? mem[a] : {a[31:0], ~a[31:0]};
  endfunction
  // model: an access granted in cycle g answers in cycle g+LAT+1, memory data is valid in cycle g+LAT
  bit pend = 0, own_dm = 0, own_we = 0, own_mis = 0;
  int resp_c = 0, ret_c = -1, starve = 0;
  logic [63:0] ret_data = 0, m_dm = 0, last_addr = 0, last_wdata = 0, mrd_next = 0;
  logic [31:0] m_if = 0;
  always @(negedge clk) begin : mdl
    bit ig, dg, rv, elig, mis;
    if (!reset) begin
      chk1("rst_if_gnt", if_gnt, 1'b0); chk1("rst_dm_gnt", dm_gnt, 1'b0);
      chk1("rst_if_rvalid", if_rvalid, 1'b0); chk1("rst_dm_rvalid", dm_rvalid, 1'b0);
      chk1("rst_mem_en", mem_en, 1'b0); chk1("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 64'd0); chk("rst_mem_wdata", mem_wdata, 64'd0);
      chk("rst_if_rdata", 64'(if_rdata), 64'd0); chk("rst_dm_rdata", dm_rdata, 64'd0);
      chk1("rst_busy", busy, 1'b0); chk1("rst_stall_if", stall_if, if_req);
      pend = 0; ret_c = -1; starve = 0; m_if = 0; m_dm = 0; last_addr = 0; last_wdata = 0;
    end else begin
      elig = !(pend && cyc < resp_c);
      ig = elig && if_req && (!dm_req || starve == SMAX);
      dg = elig && dm_req && !ig;
      mis = 0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      mis = ig ? (if_addr[1:0] != 0) : dg && (dm_addr[2:0] != 0);
`endif
      rv = pend && cyc == resp_c;
      chk1("if_gnt", if_gnt, ig); chk1("dm_gnt", dm_gnt, dg);
      chk1("mem_en", mem_en, (ig || dg) && !mis); chk1("mem_we", mem_we, dg && dm_we && !mis);
      chk("mem_addr", mem_addr, ig ? if_addr : dg ? dm_addr : last_addr);
      chk("mem_wdata", mem_wdata, dg ? dm_wdata : last_wdata);
      chk1("if_rvalid", if_rvalid, rv && !own_dm); chk1("dm_rvalid", dm_rvalid, rv && own_dm);
      chk("if_rdata", 64'(if_rdata), 64'(m_if)); chk("dm_rdata", dm_rdata, m_dm);
      chk1("stall_if", stall_if, if_req && !ig); chk1("busy", busy, pend);
`ifdef MEM_ARB_ALIGN_CHECK_EN
      chk1("if_err", if_err, rv && !own_dm && own_mis); chk1("dm_err", dm_err, rv && own_dm && own_mis);
`endif
      if (pend && !own_mis && cyc == resp_c - 1) begin
        if (own_dm) m_dm = own_we ? 64'd0 : ret_data;
        else m_if = ret_data[31:0];
      end
      if (rv) pend = 0;
      if (ig || dg) begin
        pend = 1; own_dm = dg; own_we = dg && dm_we; own_mis = mis;
        resp_c = cyc + (mis ? 1 : LAT + 1);
        last_addr = ig ? if_addr : dm_addr;
        if (dg) last_wdata = dm_wdata;
        if (mis) begin
          if (dg) m_dm = 0; else m_if = 0;
        end else if (dg && dm_we) mem[dm_addr] = dm_wdata;
        else begin
          ret_data = rd(last_addr);
          ret_c = cyc + LAT;
        end
      end
      if (dg && if_req) starve = starve < SMAX ? starve + 1 : starve;
      else if (ig || (elig && !if_req)) starve = 0;
    end
    cyc++;
    mrd_next = cyc == ret_c ? ret_data : 64'hBAD0_BAD0_BAD0_BAD0;
  end
  always @(posedge clk) begin
    #1 mem_rdata = mrd_next;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    mem[64'h100] = 64'h0000_0000_00A0_0093;
    mem[64'h104] = 64'h0000_0013_0010_0113;
    repeat (3) @(posedge clk);
    @(negedge clk) chk1("lit_rst_busy", busy, 1'b0);
    tick(); reset = 1;
    // plain fetch
    tick(); if_req = 1; if_addr = 64'h100;
    @(negedge clk) begin chk1("s1_if_gnt", if_gnt, 1'b1); chk1("s1_mem_en", mem_en, 1'b1); chk("s1_mem_addr", mem_addr, 64'h100); end
    tick(); if_req = 0;
    @(negedge clk) chk1("s1_busy1", busy, 1'b1);
    tick(); tick();
    @(negedge clk) begin chk1("s1_rvalid", if_rvalid, 1'b1); chk("s1_rdata", 64'(if_rdata), 64'h00A00093); chk1("s1_busy3", busy, 1'b1); end
    tick();
    @(negedge clk) chk1("s1_busy4", busy, 1'b0);
    // simultaneous requests: DM store wins
    tick(); if_req = 1; if_addr = 64'h104; dm_req = 1; dm_we = 1; dm_addr = 64'h200; dm_wdata = 64'hDEADBEEF;
    @(negedge clk) begin chk1("s2_dm_gnt", dm_gnt, 1'b1); chk1("s2_if_gnt0", if_gnt, 1'b0); chk1("s2_mem_we", mem_we, 1'b1); chk("s2_wdata", mem_wdata, 64'hDEADBEEF); end
    tick(); dm_req = 0; dm_we = 0;
    tick(); tick();
    @(negedge clk) begin chk1("s2_dm_rvalid", dm_rvalid, 1'b1); chk1("s2_if_gnt3", if_gnt, 1'b1); chk("s2_dm_rdata", dm_rdata, 64'd0); end
    tick(); if_req = 0;
    tick(); tick();
    @(negedge clk) begin chk1("s2_if_rvalid", if_rvalid, 1'b1); chk("s2_if_rdata", 64'(if_rdata), 64'h00100113); end
    tick(); if_req = 1; if_addr = 64'h200;
    tick(); if_req = 0;
    tick(); tick();
    @(negedge clk) chk("s2_store_readback", 64'(if_rdata), 64'hDEADBEEF);
    tick();
    // starvation: four DM wins, then IF is forced through
    tick(); if_req = 1; if_addr = 64'h108; dm_req = 1; dm_we = 0; dm_addr = 64'h208;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      @(negedge clk) begin
        chk1("s3_stall", stall_if, 1'b1);
        if (k % 3 == 0) chk1("s3_dm_gnt", dm_gnt, 1'b1);
      end
    end
    tick();
    @(negedge clk) begin chk1("s3_if_gnt", if_gnt, 1'b1); chk1("s3_dm_gnt12", dm_gnt, 1'b0); end
    tick(); if_req = 0;
    tick(); tick();
    @(negedge clk) chk1("s3_dm_gnt15", dm_gnt, 1'b1);
    tick(); dm_req = 0;
    repeat (4) tick();
    // reset in the middle of a load
    tick(); dm_req = 1; dm_we = 0; dm_addr = 64'h200;
    @(negedge clk) chk1("s4_dm_gnt", dm_gnt, 1'b1);
    tick(); dm_req = 0; reset = 0;
    @(negedge clk) begin chk1("s4_busy", busy, 1'b0); chk("s4_if_rdata", 64'(if_rdata), 64'd0); chk("s4_mem_addr", mem_addr, 64'd0); end
    tick(); reset = 1;
    tick();
    @(negedge clk) chk1("s4_no_rvalid", dm_rvalid, 1'b0);
    repeat (3) tick();
    tick(); dm_req = 1; dm_addr = 64'h200;
    @(negedge clk) chk1("s4_regrant", dm_gnt, 1'b1);
    tick(); dm_req = 0;
    tick(); tick();
    @(negedge clk) begin chk1("s4_rvalid", dm_rvalid, 1'b1); chk("s4_rdata", dm_rdata, 64'hDEADBEEF); end
    tick();
    // DM withdraws before it would win
    tick(); dm_req = 1; dm_we = 0; dm_addr = 64'h100;
    @(negedge clk) chk1("s5_dm_gnt0", dm_gnt, 1'b1);
    tick(); dm_req = 0; if_req = 1; if_addr = 64'h10C;
    tick(); dm_req = 1; dm_we = 1; dm_addr = 64'h300; dm_wdata = 64'h55;
    @(negedge clk) begin chk1("s5_stall", stall_if, 1'b1); chk1("s5_dm_gnt2", dm_gnt, 1'b0); end
    tick(); dm_req = 0;
    @(negedge clk) begin chk1("s5_if_gnt", if_gnt, 1'b1); chk1("s5_dm_gnt3", dm_gnt, 1'b0); chk1("s5_mem_we", mem_we, 1'b0); chk("s5_dm_rdata", dm_rdata, 64'h00A00093); end
    tick(); if_req = 0; dm_we = 0;
    repeat (4) tick();
`ifdef MEM_ARB_ALIGN_CHECK_EN
    // misaligned DM load answers next cycle with an error and no memory access
    tick(); dm_req = 1; dm_we = 0; dm_addr = 64'h204;
    @(negedge clk) begin chk1("s6_dm_gnt", dm_gnt, 1'b1); chk1("s6_mem_en", mem_en, 1'b0); end
    tick(); dm_req = 0;
    @(negedge clk) begin chk1("s6_rvalid", dm_rvalid, 1'b1); chk1("s6_err", dm_err, 1'b1); chk("s6_rdata", dm_rdata, 64'd0); end
    tick(); dm_req = 1; dm_addr = 64'h200;
    tick(); dm_req = 0;
    tick(); tick();
    @(negedge clk) begin chk1("s6_rvalid2", dm_rvalid, 1'b1); chk1("s6_err2", dm_err, 1'b0); chk("s6_rdata2", dm_rdata, 64'hDEADBEEF); end
`endif
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch port (IF) and the load/store data port (DM) of the pipelined RISC-V core.
- Arbitrates requests, sequences a fixed-latency memory access, and returns registered responses.
- Provides a stall indication to the pipeline.
- Sits between the fetch/MEM stages and the memory macro.

Parameters:
- ADDR_W, 64, address width of all ports.
- DATA_W, 64, memory data width; IF returns the low 32 bits.
- MEM_LAT, 2, cycles from memory sample edge to valid mem_rdata (>=1).
- STARVE_MAX, 4, consecutive IF losses before IF is forced to win.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request, held until if_gnt.
- if_addr  input  ADDR_W  fetch address.
- if_gnt  output  1  fetch granted this cycle.
- if_rvalid  output  1  fetch response valid, one-cycle pulse.
- if_rdata  output  32  instruction word.
- dm_req  input  1  data request, held until dm_gnt.
- dm_we  input  1  1 = store, 0 = load.
- dm_addr  input  ADDR_W  data address.
- dm_wdata  input  DATA_W  store data.
- dm_gnt  output  1  data granted this cycle.
- dm_rvalid  output  1  load data / store completion, one-cycle pulse.
- dm_rdata  output  DATA_W  load data (0 for stores).
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data.
- stall_if  output  1  if_req & ~if_gnt.
- busy  output  1  access outstanding (state != IDLE).

Behaviour:
- FSM states:
  - IDLE: no access outstanding.
  - WAIT: counter runs for MEM_LAT cycles.
  - RESP: registered response presented.
- Grants are combinational and issued only when the state is IDLE or RESP and at least one request is high. At most one grant per cycle.
- Grant cycle t:
  - mem_en = 1; mem_we/mem_addr/mem_wdata driven from the winner (mem_we = 0 for IF).
  - State goes to WAIT with cnt = MEM_LAT - 1.
- WAIT:
  - cnt decrements each cycle.
  - In cycle t+MEM_LAT, mem_rdata is captured into the winner's rdata register (IF: low 32 bits; DM store: 0).
  - State goes to RESP.
- RESP (cycle t+MEM_LAT+1): winner's rvalid = 1 for exactly one cycle. A new grant may be issued in the same cycle.
  - New grant → WAIT.
  - No grant → IDLE.
- Throughput: one access per MEM_LAT+1 cycles; only one access outstanding.
- Priority: DM wins when both request, except when starve_cnt == STARVE_MAX, in which case IF wins.
- starve_cnt:
  - Increments (saturating) each time IF requests and DM is granted.
  - Clears when IF is granted or when if_req is low in a grant-eligible cycle.
- Outside grant cycles: mem_en = 0, mem_we = 0; mem_addr and mem_wdata hold the last driven values.
- A request dropped before grant is legal and has no effect. Inputs are ignored after grant.
- rdata registers hold their value until the next capture for that port.
- Reset (async, active-low, any time including mid-access):
  - State → IDLE, cnt = 0, starve_cnt = 0.
  - Both rdata registers = 0; all gnt/rvalid/mem_en/mem_we = 0; mem_addr = 0, mem_wdata = 0.
  - The outstanding access is dropped and no response is produced after reset release.

Optional Feature:
- Macro: MEM_ARB_ALIGN_CHECK_EN.
- Defined:
  - Adds outputs if_err and dm_err (1 bit each, reset 0).
  - Misaligned IF (if_addr[1:0] != 0) or DM (dm_addr[2:0] != 0) is still granted, but mem_en stays 0.
  - FSM goes directly to RESP next cycle; rvalid and err pulse together; rdata = 0.
  - err is 0 on every aligned response.
- Undefined: no err ports, no alignment check, all granted accesses go to memory.

Test Plan:
- MEM_LAT = 2, reset release, IF read 0x100 (memory returns 0x00A00093) → if_gnt at cycle 0; mem_en = 1, mem_addr = 0x100; if_rvalid at cycle 3 with if_rdata = 0x00A00093; busy = 1 on cycles 1–3.
- IF and DM request the same cycle, DM store 0x200 ← 0xDEADBEEF → dm_gnt first with mem_we = 1, mem_wdata = 0xDEADBEEF; dm_rvalid at cycle 3; if_gnt at cycle 3; if_rvalid at cycle 6.
- STARVE_MAX = 4, DM and IF both requesting continuously → four DM grants, then the 5th grant goes to IF; stall_if = 1 throughout until if_gnt.
- DM load granted, reset pulled low at cycle 1 and released at cycle 2 → all outputs 0 immediately; no dm_rvalid in the following 5 cycles; next request is granted normally.
- DM request withdrawn one cycle before it would win (IF waiting) → IF is granted; no dm_gnt; mem_we = 0.
- MEM_ARB_ALIGN_CHECK_EN defined, DM load at 0x204 → dm_gnt, mem_en stays 0, next cycle dm_rvalid = 1, dm_err = 1, dm_rdata = 0; an aligned access afterwards gives dm_err = 0.
